// File: rtl/llc_input_arbiter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : llc_input_arbiter_pipe
// Purpose  : LLC front-end arbiter. Each cycle it picks one of NUM_CH request
//            channels (index 0 = highest priority). A channel that has waited
//            STARVE_LIMIT cycles is "aged" and takes precedence. The granted
//            line address is split into set/tag and queued in a FIFO_DEPTH
//            entry decoded-grant queue, which feeds the set-read stage.
// Ports    : clk, rst (sync, active-low), flush (sync queue/counter clear)
//            ch_valid/ch_block/ch_addr  -> per-channel request side
//            ch_ready                   <- one-hot grant
//            out_valid/out_ready        queue head handshake
//            out_ch/out_set/out_tag/out_aged  queue head fields
//            fifo_count                 occupied entries
//            idle                       registered: queue empty, none eligible
// Revision : 1.0  initial release
// ============================================================================
module llc_input_arbiter_pipe #(
    parameter int NUM_CH       = 4,
    parameter int ADDR_W       = 28,
    parameter int SET_BITS     = 9,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int TAG_W       = ADDR_W - SET_BITS,
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_block,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        out_ch,
    output logic [SET_BITS-1:0]      out_set,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_aged,
    output logic [CNT_W-1:0]         fifo_count,
    output logic                     idle
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [WAIT_W-1:0] c_wait_max  = WAIT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  c_cnt_full  = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WAIT_W-1:0]   r_wait   [NUM_CH];
    logic [NUM_CH-1:0]   r_q_ch   [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_q_addr [FIFO_DEPTH];
    logic                r_q_aged [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_idle;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]   w_eligible;
    logic [NUM_CH-1:0]   w_starved;
    logic [IDX_W-1:0]    w_win_idx;
    logic [NUM_CH-1:0]   w_onehot;
    logic [ADDR_W-1:0]   w_win_addr;
    logic                w_full;
    logic                w_can_push;
    logic                w_grant;
    logic                w_push;
    logic                w_pop;

    assign w_eligible = ch_valid & ~ch_block;

    always_comb begin
        w_starved = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_starved[i] = w_eligible[i] && (r_wait[i] == c_wait_max);
        end
    end

    // Scan from the top so the lowest index is written last and wins.
    // Aged channels override the plain priority pick.
    always_comb begin
        w_win_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win_idx = IDX_W'(i);
            end
        end
        if (|w_starved) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (w_starved[i]) begin
                    w_win_idx = IDX_W'(i);
                end
            end
        end
    end

    assign w_onehot   = NUM_CH'(1) << w_win_idx;
    assign w_win_addr = ch_addr[int'(w_win_idx) * ADDR_W +: ADDR_W];

    assign out_valid  = (r_count != '0);
    assign w_full     = (r_count == c_cnt_full);
    // A full queue can still accept when the head leaves in the same cycle.
    assign w_can_push = !w_full || (out_valid && out_ready);
    assign w_grant    = (|w_eligible) && w_can_push && !flush && rst;
    assign ch_ready   = w_grant ? w_onehot : '0;
    assign w_push     = |(ch_valid & ch_ready);
    assign w_pop      = out_valid && out_ready && !flush;

    // ------------------------------------------------------------------
    // Starvation counters: count consecutive eligible-but-not-granted
    // cycles, including cycles where a full queue suppressed every grant.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_eligible[i] || ch_ready[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != c_wait_max) begin
                    r_wait[i] <= r_wait[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decoded-grant queue
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_q_ch[i]   <= '0;
                r_q_addr[i] <= '0;
                r_q_aged[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_q_ch[r_wr_ptr]   <= w_onehot;
            r_q_addr[r_wr_ptr] <= w_win_addr;
            r_q_aged[r_wr_ptr] <= |w_starved;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idle <= 1'b0;
        end else begin
            r_idle <= (r_count == '0) && !(|w_eligible);
        end
    end

    // Head fields come straight from queue storage; no bypass of new grants.
    assign out_ch     = r_q_ch[r_rd_ptr];
    assign out_set    = r_q_addr[r_rd_ptr][SET_BITS-1:0];
    assign out_tag    = r_q_addr[r_rd_ptr][ADDR_W-1:SET_BITS];
    assign out_aged   = r_q_aged[r_rd_ptr];
    assign fifo_count = r_count;
    assign idle       = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_llc_input_arbiter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_llc_input_arbiter_pipe
// Purpose  : Directed self-checking bench for llc_input_arbiter_pipe.
// Revision : 1.0  initial release
// ============================================================================
module tb_llc_input_arbiter_pipe;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 28;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_block;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_CH-1:0]        out_ch;
    logic [8:0]               out_set;
    logic [18:0]              out_tag;
    logic                     out_aged;
    logic [2:0]               fifo_count;
    logic                     idle;

    int n_pass  = 0;
    int n_total = 0;

    llc_input_arbiter_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .ch_valid   (ch_valid),
        .ch_block   (ch_block),
        .ch_addr    (ch_addr),
        .ch_ready   (ch_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_set    (out_set),
        .out_tag    (out_tag),
        .out_aged   (out_aged),
        .fifo_count (fifo_count),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are changed and outputs sampled 2 time
    // units after the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Return to a clean state (empty queue, zeroed wait counters).
    task automatic clean();
        ch_valid  = '0;
        ch_block  = '0;
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ch_valid = 4'hF; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++; if (ch_ready !== 4'b0000) $display("FAIL reset_ready cyc%0d got %b exp 0000", k, ch_ready); else n_pass++;
            n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
            n_total++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", fifo_count); else n_pass++;
        end
        n_total++; if (idle !== 1'b0) $display("FAIL reset_idle got %b exp 0", idle); else n_pass++;
        n_total++; if ({out_ch, out_set, out_tag, out_aged} !== '0) $display("FAIL reset_head got %h exp 0", {out_ch, out_set, out_tag, out_aged}); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (ch_ready !== 4'b0001) $display("FAIL first_grant got %b exp 0001", ch_ready); else n_pass++;
        tick();
        ch_valid = '0;
        #1;
        n_total++; if (out_valid !== 1'b1 || out_ch !== 4'b0001) $display("FAIL first_entry got v=%b ch=%b exp v=1 ch=0001", out_valid, out_ch); else n_pass++;
        clean();
    endtask

    task automatic test_priority();
        ch_addr[1*ADDR_W +: ADDR_W] = 28'h0ABC123;
        ch_addr[2*ADDR_W +: ADDR_W] = 28'h0000777;
        ch_valid = 4'b0110;
        #1;
        n_total++; if (ch_ready !== 4'b0010) $display("FAIL prio_ready got %b exp 0010", ch_ready); else n_pass++;
        tick();
        ch_valid = '0;
        #1;
        n_total++; if (out_ch !== 4'b0010) $display("FAIL prio_out_ch got %b exp 0010", out_ch); else n_pass++;
        n_total++; if (out_set !== 9'h123) $display("FAIL prio_set got %h exp 123", out_set); else n_pass++;
        // tag = 0x0ABC123 >> 9
        n_total++; if (out_tag !== 19'h055E0) $display("FAIL prio_tag got %h exp 055e0", out_tag); else n_pass++;
        n_total++; if (out_aged !== 1'b0) $display("FAIL prio_aged got %b exp 0", out_aged); else n_pass++;
        n_total++; if (fifo_count !== 3'd1) $display("FAIL prio_count got %0d exp 1", fifo_count); else n_pass++;
        clean();
    endtask

    task automatic test_aging();
        ch_valid = 4'b1001; out_ready = 1'b1;
        #1;
        // Two rounds: the second shows ch3's wait counter restarted at 0.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                n_total++; if (ch_ready !== 4'b0001) $display("FAIL aging_ch0 r%0d k%0d got %b exp 0001", r, k, ch_ready); else n_pass++;
                tick();
            end
            n_total++; if (out_aged !== 1'b0) $display("FAIL aging_plain_aged r%0d got %b exp 0", r, out_aged); else n_pass++;
            n_total++; if (ch_ready !== 4'b1000) $display("FAIL aging_ch3 r%0d got %b exp 1000", r, ch_ready); else n_pass++;
            tick();
            n_total++; if (out_ch !== 4'b1000 || out_aged !== 1'b1) $display("FAIL aging_head r%0d got ch=%b aged=%b exp ch=1000 aged=1", r, out_ch, out_aged); else n_pass++;
        end
        clean();
    endtask

    task automatic test_full();
        out_ready = 1'b0; ch_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            ch_addr[0 +: ADDR_W] = 28'(k);
            #1;
            n_total++; if (ch_ready !== 4'b0001) $display("FAIL full_accept k%0d got %b exp 0001", k, ch_ready); else n_pass++;
            tick();
        end
        ch_addr[0 +: ADDR_W] = 28'd4;
        #1;
        n_total++; if (fifo_count !== 3'd4) $display("FAIL full_count got %0d exp 4", fifo_count); else n_pass++;
        n_total++; if (ch_ready !== 4'b0000) $display("FAIL full_ready got %b exp 0000", ch_ready); else n_pass++;
        n_total++; if (out_set !== 9'd0) $display("FAIL full_head got %0d exp 0", out_set); else n_pass++;
        out_ready = 1'b1;
        #1;
        n_total++; if (ch_ready !== 4'b0001) $display("FAIL full_pushpop_ready got %b exp 0001", ch_ready); else n_pass++;
        tick();
        n_total++; if (fifo_count !== 3'd4) $display("FAIL full_pushpop_count got %0d exp 4", fifo_count); else n_pass++;
        n_total++; if (out_set !== 9'd1) $display("FAIL full_pushpop_head got %0d exp 1", out_set); else n_pass++;
        clean();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; ch_valid = 4'b0110;
        for (int k = 0; k < 3; k++) tick();
        n_total++; if (fifo_count !== 3'd3) $display("FAIL flush_pre_count got %0d exp 3", fifo_count); else n_pass++;
        flush = 1'b1;
        #1;
        n_total++; if (ch_ready !== 4'b0000) $display("FAIL flush_ready got %b exp 0000", ch_ready); else n_pass++;
        tick();
        flush = 1'b0; out_ready = 1'b1;
        #1;
        n_total++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) $display("FAIL flush_clear got cnt=%0d v=%b exp cnt=0 v=0", fifo_count, out_valid); else n_pass++;
        // ch2 had waited 3 cycles before flush; a cleared counter means it
        // needs a full 8 losses again before aging.
        for (int k = 0; k < 8; k++) begin
            n_total++; if (ch_ready !== 4'b0010) $display("FAIL flush_resume k%0d got %b exp 0010", k, ch_ready); else n_pass++;
            tick();
        end
        n_total++; if (ch_ready !== 4'b0100) $display("FAIL flush_aged_ch2 got %b exp 0100", ch_ready); else n_pass++;
        clean();
    endtask

    task automatic test_block();
        out_ready = 1'b1; ch_valid = 4'b0011; ch_block = 4'b0001;
        #1;
        n_total++; if (ch_ready !== 4'b0010) $display("FAIL block_ready got %b exp 0010", ch_ready); else n_pass++;
        for (int k = 0; k < 10; k++) tick();
        // A blocked channel must not accumulate wait; unblocking it yields
        // an ordinary (non-aged) grant.
        ch_block = 4'b0000;
        #1;
        n_total++; if (ch_ready !== 4'b0001) $display("FAIL unblock_ready got %b exp 0001", ch_ready); else n_pass++;
        tick();
        n_total++; if (out_ch !== 4'b0001 || out_aged !== 1'b0) $display("FAIL unblock_head got ch=%b aged=%b exp ch=0001 aged=0", out_ch, out_aged); else n_pass++;
        ch_block = 4'b1111;
        tick();
        n_total++; if (fifo_count !== 3'd0 || idle !== 1'b0) $display("FAIL idle_drain got cnt=%0d idle=%b exp cnt=0 idle=0", fifo_count, idle); else n_pass++;
        tick();
        n_total++; if (idle !== 1'b1) $display("FAIL idle_set got %b exp 1", idle); else n_pass++;
        clean();
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; ch_valid = '0; ch_block = '0;
        ch_addr = '0; out_ready = 1'b0;
        test_reset();
        test_priority();
        test_aging();
        test_full();
        test_flush();
        test_block();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
